sc_phase_generator: RTL
=======================

SC_PHASE_GENERATOR -- requirements
Module: sc_phase_generator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of all phase-length and dead-time counters and config ports.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port enable  input  1  1 = run phase sequence; 0 = stop at the next cycle boundary.
REQ-005 The block SHALL have port ph1_len  input  CNT_W  phi1 high time in clk cycles.
REQ-006 The block SHALL have port ph2_len  input  CNT_W  phi2 high time in clk cycles.
REQ-007 The block SHALL have port dead_len  input  CNT_W  non-overlap gap in clk cycles, applied after each phase.
REQ-008 The block SHALL have port phi1  output  1  switched-capacitor filter phase 1 (sampling).
REQ-009 The block SHALL have port phi2  output  1  switched-capacitor filter phase 2 (integration).
REQ-010 The block SHALL have port busy  output  1  high in every non-IDLE state.
REQ-011 The block SHALL have port cycle_done  output  1  single-cycle pulse on the last cycle of DEAD21.

Function
REQ-012 The block SHALL implement a five-state FSM: IDLE, PHI1, DEAD12, PHI2, DEAD21.
REQ-013 IDLE -> PHI1 SHALL occur on the first clk edge with enable=1; IDLE SHALL hold otherwise.
REQ-014 Each timed state SHALL last exactly its effective length: PHI1 = ph1_len, DEAD12 = dead_len, PHI2 = ph2_len, DEAD21 = dead_len; then advance PHI1->DEAD12->PHI2->DEAD21.
REQ-015 Effective length SHALL be max(config, 1): a zero length counts as 1 cycle, so a dead time is never skipped.
REQ-016 ph1_len, ph2_len and dead_len SHALL be sampled into shadow registers only on IDLE->PHI1 and DEAD21->PHI1; mid-cycle config changes SHALL have no effect until the next PHI1 entry.
REQ-017 phi1 and phi2 SHALL each be driven directly from a flop, with no combinational output path.
REQ-018 phi1 SHALL be 1 exactly during the PHI1 state; phi2 SHALL be 1 exactly during the PHI2 state. phi1 & phi2 SHALL never both be 1.
REQ-019 At the end of DEAD21, the FSM SHALL go to PHI1 if enable=1, else to IDLE; enable is sampled only at that point and at IDLE.
REQ-020 If enable is deasserted mid-sequence, the current PHI1..DEAD21 sequence SHALL complete in full (no truncated phase).
REQ-021 cycle_done SHALL be 1 for exactly the final cycle of DEAD21, independent of enable.
REQ-022 The full period SHALL equal ph1 + ph2 + 2*dead (effective values), with no extra idle cycle between consecutive sequences.
REQ-023 Counters SHALL count down from effective length minus 1 to 0 and SHALL reload on each state change, with no wrap-around hazard at the maximum value 2^CNT_W-1.

Reset
REQ-024 When rst_n=0 is sampled at a clk edge, the block SHALL go to IDLE, clear the counters, and set phi1=0, phi2=0, busy=0, cycle_done=0 from the next cycle.
REQ-025 Reset SHALL override every state, including mid-PHI1 or mid-PHI2; no dead-time completion is required on reset.
REQ-026 Shadow config registers SHALL reset to 1.

Structure
REQ-027 A shared package sc_pkg SHALL hold the FSM state enum (phase_state_t) and the default-length constants (PH_LEN_DEF=4, DEAD_LEN_DEF=1).
REQ-028 One sub-module, sc_phase_counter (loadable down-counter with a zero flag, width CNT_W), SHALL be instantiated once and shared across all timed states.

Verification
REQ-029 The bench SHALL cover: ph1=3, ph2=3, dead=1, enable=1 -> phi1 high 3 cycles, both low 1, phi2 high 3, both low 1; period 8; cycle_done every 8th cycle.
REQ-030 The bench SHALL cover: dead_len=0, ph1=ph2=2 -> 1-cycle gaps still present; period 6; phi1&phi2 never 1.
REQ-031 The bench SHALL cover: enable dropped in the 2nd cycle of PHI1 (ph=4, dead=2) -> phi1 completes 4 cycles, phi2 completes 4 cycles, DEAD21 completes, then IDLE with busy=0.
REQ-032 The bench SHALL cover: ph1_len changed 3->5 mid-PHI2 -> current sequence unchanged; next phi1 pulse is 5 cycles.
REQ-033 The bench SHALL cover: rst_n=0 asserted mid-PHI2 -> phi2=0, busy=0 next cycle; with enable=1 and rst_n released, phi1 rises 1 cycle after release with the current config.
REQ-034 The bench SHALL cover: ph1=ph2=255, dead=255 at CNT_W=8 -> each state lasts 255 cycles; period 1020.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the switched-capacitor two-phase clock generator.
//   phase_state_t : FSM states of sc_phase_generator
//   PH_LEN_DEF    : default phase length (clk cycles) for integrators/benches
//   DEAD_LEN_DEF  : default non-overlap gap (clk cycles)
package sc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PHI1   = 3'd1,
    DEAD12 = 3'd2,
    PHI2   = 3'd3,
    DEAD21 = 3'd4
  } phase_state_t;

  localparam int PH_LEN_DEF   = 4;
  localparam int DEAD_LEN_DEF = 1;

endpackage

// File: rtl/sc_phase_counter.sv
// Loadable down-counter shared by all timed phases of sc_phase_generator.
//   clk, rst_n : clock, synchronous active-low reset (clears count)
//   load       : load load_val this cycle (has priority over counting)
//   load_val   : value loaded (effective length minus one)
//   count      : current count
//   zero       : count == 0; the counter holds at zero rather than wrapping
module sc_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!zero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sc_phase_generator.sv
// Non-overlapping two-phase clock generator for switched-capacitor filters.
// Sequence: PHI1 -> DEAD12 -> PHI2 -> DEAD21, repeated while enable is high
// at each sequence boundary. Zero lengths count as one cycle.
//   clk, rst_n  : clock, synchronous active-low reset
//   enable      : run request, sampled in IDLE and on the last DEAD21 cycle
//   ph1_len     : phi1 high time (clk cycles)
//   ph2_len     : phi2 high time (clk cycles)
//   dead_len    : gap after each phase (clk cycles)
//   phi1, phi2  : registered phase outputs, never high together
//   busy        : high in any non-IDLE state
//   cycle_done  : one-cycle pulse on the final DEAD21 cycle
module sc_phase_generator
  import sc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] ph1_len,
  input  logic [CNT_W-1:0] ph2_len,
  input  logic [CNT_W-1:0] dead_len,
  output logic             phi1,
  output logic             phi2,
  output logic             busy,
  output logic             cycle_done
);

  phase_state_t     state;
  logic [CNT_W-1:0] sh_ph2_len;
  logic [CNT_W-1:0] sh_dead_len;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_zero;

  // Counter reload for a configured length: max(len,1) - 1, never wraps.
  function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  // Entry into PHI1 loads from the live ph1_len because the shadow copy is
  // only captured on that same edge; later phases use the shadows.
  // NOTE: defaults at the top of always_comb keep every path assigned, so no
  // latch is inferred.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state)
      IDLE: begin
        cnt_load     = enable;
        cnt_load_val = reload_of(ph1_len);
      end
      PHI1: begin
        cnt_load     = cnt_zero;
        cnt_load_val = reload_of(sh_dead_len);
      end
      DEAD12: begin
        cnt_load     = cnt_zero;
        cnt_load_val = reload_of(sh_ph2_len);
      end
      PHI2: begin
        cnt_load     = cnt_zero;
        cnt_load_val = reload_of(sh_dead_len);
      end
      DEAD21: begin
        cnt_load     = cnt_zero & enable;
        cnt_load_val = reload_of(ph1_len);
      end
      default: begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
      end
    endcase
  end

  sc_phase_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // Outputs are registered and set on the edge that enters each state, so
  // they line up exactly with the state they describe. cycle_done is raised
  // on the edge that enters the final DEAD21 cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh_ph2_len  <= CNT_W'(1);
      sh_dead_len <= CNT_W'(1);
      phi1        <= 1'b0;
      phi2        <= 1'b0;
      busy        <= 1'b0;
      cycle_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state       <= PHI1;
            sh_ph2_len  <= ph2_len;
            sh_dead_len <= dead_len;
            phi1        <= 1'b1;
            busy        <= 1'b1;
          end
        end
        PHI1: begin
          if (cnt_zero) begin
            state <= DEAD12;
            phi1  <= 1'b0;
          end
        end
        DEAD12: begin
          if (cnt_zero) begin
            state <= PHI2;
            phi2  <= 1'b1;
          end
        end
        PHI2: begin
          if (cnt_zero) begin
            state      <= DEAD21;
            phi2       <= 1'b0;
            cycle_done <= (reload_of(sh_dead_len) == '0);
          end
        end
        DEAD21: begin
          if (cnt_zero) begin
            cycle_done <= 1'b0;
            if (enable) begin
              state       <= PHI1;
              sh_ph2_len  <= ph2_len;
              sh_dead_len <= dead_len;
              phi1        <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cycle_done <= (cnt_count == CNT_W'(1));
          end
        end
        default: begin
          state <= IDLE;
          phi1  <= 1'b0;
          phi2  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
